// File: rtl/vt52_key_encoder.sv
// rtl/vt52_key_encoder.sv - VT52 keyboard/identify encoder feeding a UART byte stream
// Key FIFO, identify pending flag, and a 3-byte sequence register drained by a two-state FSM.
module vt52_key_encoder #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         key_data,
    input  logic               key_strobe,
    input  logic               ident_req,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               key_drop,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic                 ident_pend_q, ident_pend_d;
    logic                 drop_q, drop_d;
    logic [2:0][7:0]      seq_q, seq_d;
    logic [1:0]           len_q, len_d, idx_q, idx_d;
    logic                 push, pop, ident_clr, full, empty;
    logic [7:0]           head, cursor_byte;

    // Level can only reach DEPTH, so its MSB alone flags full.
    assign full  = level_q[FIFO_AW];
    assign empty = (level_q == '0);
    assign head  = mem[rd_ptr_q];

    always_comb begin
        cursor_byte = 8'h41;
        case (head[2:0])
            3'd0: cursor_byte = 8'h41;
            3'd1: cursor_byte = 8'h42;
            3'd2: cursor_byte = 8'h43;
            3'd3: cursor_byte = 8'h44;
            3'd4: cursor_byte = 8'h48;
            3'd5: cursor_byte = 8'h50;
            3'd6: cursor_byte = 8'h51;
            default: cursor_byte = 8'h52;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        len_d     = len_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        ident_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ident_pend_q) begin
                    seq_d     = {8'h4B, 8'h2F, 8'h1B};
                    len_d     = 2'd3;
                    idx_d     = 2'd0;
                    ident_clr = 1'b1;
                    state_d   = S_SEND;
                end else if (!empty) begin
                    pop   = 1'b1;
                    idx_d = 2'd0;
                    if (!head[7]) begin
                        seq_d   = {16'h0000, head};
                        len_d   = 2'd1;
                        state_d = S_SEND;
                    end else if (head[6:3] == 4'd0) begin
                        seq_d   = {8'h00, cursor_byte, 8'h1B};
                        len_d   = 2'd2;
                        state_d = S_SEND;
                    end
                    // Codes 88..FF are popped with nothing loaded.
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (idx_q == len_q - 2'd1) begin
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push     = key_strobe && !full;
        drop_d   = key_strobe && full;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A request on the load cycle counts as a new request.
        ident_pend_d = (ident_pend_q && !ident_clr) || ident_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ident_pend_q <= 1'b0;
            drop_q       <= 1'b0;
            seq_q        <= '0;
            len_q        <= 2'd1;
            idx_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ident_pend_q <= ident_pend_d;
            drop_q       <= drop_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= key_data;
        end
    end

    always_comb begin
        m_axis_tdata = seq_q[0];
        case (idx_q)
            2'd0:    m_axis_tdata = seq_q[0];
            2'd1:    m_axis_tdata = seq_q[1];
            default: m_axis_tdata = seq_q[2];
        endcase
    end

    assign m_axis_tvalid = (state_q == S_SEND);
    assign key_drop      = drop_q;
    assign fifo_level    = level_q;
endmodule

// File: tb/tb_vt52_key_encoder.sv
// tb/tb_vt52_key_encoder.sv - self-checking bench for vt52_key_encoder
// Expected byte stream is a queue of beats built from the key mapping table.
module tb_vt52_key_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic       key_strobe = 1'b0;
    logic       ident_req = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       key_drop;
    logic [3:0] fifo_level;

    vt52_key_encoder #(.FIFO_AW(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_data      (key_data),
        .key_strobe    (key_strobe),
        .ident_req     (ident_req),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .key_drop      (key_drop),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    drop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_key(input logic [7:0] code);
        logic [7:0] cursor [8];
        beat_t bt;
        cursor = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h50, 8'h51, 8'h52};
        if (code < 8'h80) begin
            bt.b = code; bt.last = 1; exp_q.push_back(bt);
        end else if (code <= 8'h87) begin
            bt.b = 8'h1B; bt.last = 0; exp_q.push_back(bt);
            bt.b = cursor[code - 8'h80]; bt.last = 1; exp_q.push_back(bt);
        end
    endfunction

    function automatic void push_ident();
        beat_t bt;
        bt.b = 8'h1B; bt.last = 0; exp_q.push_back(bt);
        bt.b = 8'h2F; bt.last = 0; exp_q.push_back(bt);
        bt.b = 8'h4B; bt.last = 1; exp_q.push_back(bt);
    endfunction

    // Beat scoreboard, hold-while-stalled and inter-sequence spacing checks.
    bit         prev_accept = 0, prev_last = 0, prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            prev_accept = 0;
            prev_stall  = 0;
        end else begin
            if (key_drop) drop_cnt++;
            if (prev_accept) chk("seq_spacing_tvalid", m_axis_tvalid, !prev_last);
            if (prev_stall) begin
                chk("stall_tvalid_held", m_axis_tvalid, 1);
                chk("stall_tdata_held", m_axis_tdata, prev_data);
            end
            prev_accept = 0;
            prev_stall  = m_axis_tvalid && !m_axis_tready;
            prev_data   = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t bt;
                    bt = exp_q.pop_front();
                    chk("beat_tdata", m_axis_tdata, bt.b);
                    prev_accept = 1;
                    prev_last   = bt.last;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] code, input bit expect_push);
        key_data   = code;
        key_strobe = 1'b1;
        if (expect_push) push_key(code);
        tick();
        key_strobe = 1'b0;
    endtask

    task automatic ident();
        ident_req = 1'b1;
        tick();
        ident_req = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !m_axis_tvalid; i++) tick();
        chk("wait_tvalid", m_axis_tvalid, 1);
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
        tick();
        tick();
        chk("drain_idle_tvalid", m_axis_tvalid, 0);
        chk("drain_fifo_level", fifo_level, 0);
    endtask

    initial begin
        int drops0;
        #2;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 8'h00);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", key_drop, 0);
        tick();
        reset = 1'b0;
        m_axis_tready = 1'b1;
        tick();

        // Latency: strobe captured at end of cycle N, tvalid at N+2.
        strobe(8'h41, 1);
        chk("lat_n1_tvalid", m_axis_tvalid, 0);
        tick();
        chk("lat_n2_tvalid", m_axis_tvalid, 1);
        chk("lat_n2_tdata", m_axis_tdata, 8'h41);
        drain();

        // Cursor up stalled for 5 cycles.
        m_axis_tready = 1'b0;
        strobe(8'h80, 1);
        wait_valid();
        repeat (5) tick();
        chk("stall_first_byte", m_axis_tdata, 8'h1B);
        drain();

        // Simultaneous identify and key: identify goes first.
        key_data   = 8'h83;
        key_strobe = 1'b1;
        ident_req  = 1'b1;
        push_ident();
        push_key(8'h83);
        tick();
        key_strobe = 1'b0;
        ident_req  = 1'b0;
        drain();

        // Two identify requests while pending merge into one response.
        m_axis_tready = 1'b0;
        strobe(8'h41, 1);
        wait_valid();
        ident();
        tick();
        ident();
        push_ident();
        drain();

        // FIFO saturation behind a stalled sequence; the ninth key is lost.
        m_axis_tready = 1'b0;
        strobe(8'h2A, 1);
        wait_valid();
        drops0 = drop_cnt;
        for (int i = 0; i < 9; i++) strobe(8'h30 + 8'(i), i < 8);
        chk("sat_level", fifo_level, 8);
        chk("sat_drop_pulse", key_drop, 1);
        tick();
        chk("sat_drop_cleared", key_drop, 0);
        chk("sat_drop_count", drop_cnt - drops0, 1);
        drain();

        // Unmapped code silently discarded.
        m_axis_tready = 1'b1;
        strobe(8'h90, 1);
        strobe(8'h31, 1);
        drain();

        // Randomized keys with random backpressure; FIFO kept from filling.
        drops0 = drop_cnt;
        for (int c = 0; c < 400; c++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_level < 4'd7) begin
                logic [7:0] code;
                case ($urandom_range(0, 3))
                    0: code = 8'($urandom_range(8'h80, 8'h87));
                    1: code = 8'($urandom_range(8'h88, 8'hFF));
                    default: code = 8'($urandom_range(8'h00, 8'h7F));
                endcase
                strobe(code, 1);
            end else begin
                tick();
            end
        end
        drain();
        chk("rand_no_drop", drop_cnt - drops0, 0);

        // Reset after the first identify byte is accepted.
        m_axis_tready = 1'b0;
        key_data   = 8'h61;
        key_strobe = 1'b1;
        ident_req  = 1'b1;
        tick();
        ident_req  = 1'b0;
        key_data   = 8'h62;
        tick();
        key_strobe = 1'b0;
        push_ident();
        wait_valid();
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        tick();
        chk("pre_rst_tdata", m_axis_tdata, 8'h2F);
        reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_level", fifo_level, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        m_axis_tready = 1'b1;
        repeat (20) tick();
        chk("post_rst_idle", m_axis_tvalid, 0);
        chk("post_rst_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vt52_key_encoder.md
Name: vt52_key_encoder

Overview:
Terminal-to-host half of the VT52 link, mirroring the command handler that decodes host escape sequences into screen updates. It accepts keyboard key codes and identify requests from the screen-side decoder. It turns them into VT52 byte sequences: plain ASCII, cursor-key escapes, and the ESC / K identify response. Bytes go out on an AXI-stream master that feeds the UART transmit input. A small input FIFO absorbs key bursts while the UART is busy.

Parameters:
FIFO_AW, 3, FIFO address bits; depth = 2**FIFO_AW (default 8 entries)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_data  in  8  key code, valid when key_strobe=1
key_strobe  in  1  single-cycle key event pulse
ident_req  in  1  single-cycle pulse; host sent ESC Z, identify response required
m_axis_tdata  out  8  byte to UART transmitter
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  UART accepts byte
key_drop  out  1  one-cycle pulse; key lost because FIFO full
fifo_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high): FIFO empty, fifo_level=0, ident_pend=0, state=S_IDLE, m_axis_tdata=8'h00, m_axis_tvalid=0, key_drop=0. Reset mid-sequence abandons the sequence; nothing resumes after reset.
- Key FIFO:
  - Push on key_strobe when level < depth.
  - Full test uses the registered level. A strobe while full is dropped, even if a pop happens in the same cycle; key_drop=1 for the following cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo depth.
- ident_pend: set by ident_req, cleared when the identify sequence is loaded. Repeated requests while pending merge into one response.
- Key code mapping (bytes in transmit order):
  - 8'h00-8'h7F -> same single byte.
  - 8'h80 up -> 1B 41
  - 8'h81 down -> 1B 42
  - 8'h82 right -> 1B 43
  - 8'h83 left -> 1B 44
  - 8'h84 home -> 1B 48
  - 8'h85 PF1 -> 1B 50
  - 8'h86 PF2 -> 1B 51
  - 8'h87 PF3 -> 1B 52
  - 8'h88-8'hFF -> no output; entry popped and discarded.
  - Identify -> 1B 2F 4B.
- Sequence register: 3 bytes plus length (1..3) plus byte index.
- FSM:
  - S_IDLE, priority order:
    1. ident_pend: load identify sequence, clear pend, go to S_SEND.
    2. Else FIFO non-empty: pop, decode. Valid code: load, go to S_SEND. Unmapped code: stay in S_IDLE.
    3. Else stay in S_IDLE.
  - S_SEND: tvalid=1, tdata = seq[idx]. On tvalid & tready:
    - If idx == len-1, return to S_IDLE with tvalid=0 in the next cycle.
    - Else increment idx; the next byte is presented in the next cycle with tvalid still 1.
- AXI rules:
  - tdata is held stable while tvalid & !tready.
  - tvalid never drops without a handshake.
  - Sequences are never interleaved; an identify request arriving mid-sequence waits for the current sequence to finish.
- Latency: with the block idle and FIFO empty, a strobe at cycle N gives tvalid=1 at cycle N+2. Exactly one idle cycle separates consecutive sequences.
- Simultaneous key_strobe and ident_req: the key is enqueued, and the identify response is sent first.

Test Plan:
- Reset, then key_strobe 8'h41 at cycle N with tready=1 -> tvalid at N+2, tdata 8'h41, one beat, fifo_level returns to 0.
- Key 8'h80 with tready held 0 for 5 cycles, then 1 -> tdata 8'h1B stable through the stall, then 8'h41 with no tvalid gap, then tvalid=0.
- ident_req and key 8'h83 in the same cycle -> stream 1B 2F 4B, one idle cycle, then 1B 44. Two ident_req pulses while pending -> only one 1B 2F 4B.
- tready=0, 9 strobes with codes 8'h30-8'h38 (depth 8) -> fifo_level saturates at 8, one key_drop pulse. After release: bytes 30..37 in order; 8'h38 never sent.
- Keys 8'h90, 8'h31 -> only 8'h31 transmitted; 8'h90 silently discarded.
- Assert reset in the middle of 1B 2F 4B (after 1B accepted) -> tvalid=0 immediately, fifo_level=0. No residual bytes after release, even with tready=1.
